// File: rtl/instr_fetch_resp_pkg.sv
// rtl/instr_fetch_resp_pkg.sv - shared widths and FSM encoding for the instruction fetch responder
package instr_fetch_resp_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_store.sv
// rtl/instr_store.sv - program storage with synchronous write and registered read port
import instr_fetch_resp_pkg::*;

module instr_store #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Contents survive reset; only the write strobe is blocked while rst is low.
   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read register doubles as the instr output, so it only moves on rd_en.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/instr_fetch_resp.sv
// rtl/instr_fetch_resp.sv - request/response instruction fetch FSM in front of instr_store
import instr_fetch_resp_pkg::*;

module instr_fetch_resp #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ADDR_W-1:0] address,
   output logic              ready,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   input  logic              ack,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   fetch_state_t      state_q;
   fetch_state_t      state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              addr_load;
   logic              rd_en;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         if (addr_load) begin
            addr_q <= address;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ready       = 1'b0;
      instr_valid = 1'b0;
      rd_en       = 1'b0;
      addr_load   = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (req) begin
               addr_load = 1'b1;
               state_d   = READ;
            end
         end
         READ: begin
            rd_en   = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            instr_valid = 1'b1;
            // Accept-on-complete: a new request rides on the same edge as the ack.
            ready       = ack;
            if (ack) begin
               if (req) begin
                  addr_load = 1'b1;
                  state_d   = READ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   instr_store #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (addr_q),
      .rd_data (instr)
   );

endmodule

// File: tb/tb_instr_fetch_resp.sv
// tb/tb_instr_fetch_resp.sv - scoreboard bench for instr_fetch_resp with a transaction-level model
module tb_instr_fetch_resp;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req = 1'b0;
   logic [4:0] address = '0;
   logic       ready;
   logic       instr_valid;
   logic [7:0] instr;
   logic       ack = 1'b0;
   logic       wr_en = 1'b0;
   logic [4:0] wr_addr = '0;
   logic [7:0] wr_data = '0;

   instr_fetch_resp dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .address     (address),
      .ready       (ready),
      .instr_valid (instr_valid),
      .instr       (instr),
      .ack         (ack),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data)
   );

   always #5 clk = ~clk;

   logic [7:0] m_mem [32];
   logic [7:0] exp_q [$];
   logic [7:0] m_instr = '0;
   logic [4:0] m_addr = '0;
   bit         pending = 0;
   bit         presenting = 0;
   bit         checking = 0;
   int         vectors = 0;
   int         miscompares = 0;

   // Transaction-level model: a fetch accepted at one edge samples storage at the
   // next edge (seeing earlier writes only) and is presented until acknowledged.
   task automatic model_update();
      bit acc;
      if (!rst) begin
         pending    = 0;
         presenting = 0;
         m_instr    = '0;
         exp_q.delete();
      end else begin
         acc = req && ((!pending && !presenting) || (presenting && ack));
         if (pending) begin
            exp_q.push_back(m_mem[m_addr]);
            m_instr    = m_mem[m_addr];
            pending    = 0;
            presenting = 1;
         end else if (presenting && ack) begin
            presenting = 0;
         end
         if (acc) begin
            pending = 1;
            m_addr  = address;
         end
         if (wr_en) m_mem[wr_addr] = wr_data;
      end
   endtask

   task automatic step(input logic r, input logic [4:0] a, input logic k,
                       input logic we, input logic [4:0] wa, input logic [7:0] wd,
                       input logic rs);
      req = r; address = a; ack = k;
      wr_en = we; wr_addr = wa; wr_data = wd; rst = rs;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
   endtask

   always @(negedge clk) begin
      if (checking) begin
         vectors++;
         if (ready !== ((!pending && !presenting) || (presenting && ack))) begin
            miscompares++;
            $display("FAIL ready: got %b want %b at %0t", ready,
                     (!pending && !presenting) || (presenting && ack), $time);
         end
         vectors++;
         if (instr_valid !== presenting) begin
            miscompares++;
            $display("FAIL instr_valid: got %b want %b at %0t", instr_valid, presenting, $time);
         end
         vectors++;
         if (presenting) begin
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL scoreboard_empty: got instr %h want none at %0t", instr, $time);
            end else begin
               if (instr !== exp_q[0]) begin
                  miscompares++;
                  $display("FAIL instr: got %h want %h at %0t", instr, exp_q[0], $time);
               end
               if (ack) void'(exp_q.pop_front());
            end
         end else if (instr !== m_instr) begin
            miscompares++;
            $display("FAIL instr_idle: got %h want %h at %0t", instr, m_instr, $time);
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      step(1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 8'h55, 1'b0);
      step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
      checking = 1;

      for (int i = 0; i < 32; i++)
         step(1'b0, 5'd0, 1'b0, 1'b1, 5'(i), 8'($urandom), 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 8'h3A, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b1, 5'd6, 8'hC1, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b1, 5'd31, 8'hFF, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 8'h11, 1'b1);

      // load + stall + back-to-back
      step(1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
      idle(4);
      step(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
      // collision: write 0x77@5 during READ of 5
      step(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 8'h77, 1'b1);
      step(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
      // reset during READ, with a write that must be ignored
      step(1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 8'h99, 1'b0);
      idle(2);
      step(1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
      // wrap: 31 then 0
      step(1'b1, 5'd31, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
      step(1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
      idle(1);

      for (int i = 0; i < 800; i++)
         step(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 3), 5'($urandom), 8'($urandom),
              ($urandom_range(0, 49) != 0));
      idle(2);

      checking = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_fetch_resp.md
INSTR_FETCH_RESP -- requirements
Module: instr_fetch_resp

Interface
REQ-001 Parameter ADDR_W, default 5, instruction address width.
REQ-002 Parameter DATA_W, default 8, instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req  input  1  fetch request from program counter side.
REQ-006 address  input  ADDR_W  fetch address; sampled only on acceptance.
REQ-007 ready  output  1  responder can accept a request this cycle.
REQ-008 instr_valid  output  1  instr holds a valid fetched word.
REQ-009 instr  output  DATA_W  fetched instruction word.
REQ-010 ack  input  1  consumer takes instr; meaningful only while instr_valid.
REQ-011 wr_en  input  1  program-load write strobe.
REQ-012 wr_addr  input  ADDR_W  program-load address.
REQ-013 wr_data  input  DATA_W  program-load data.

Function
REQ-014 Storage: 2**ADDR_W words of DATA_W bits; write when wr_en high, at the clock edge, in any FSM state.
REQ-015 FSM states: IDLE, READ, RESP.
REQ-016 IDLE: ready=1, instr_valid=0; req=1 -> latch address, go READ.
REQ-017 READ: ready=0, instr_valid=0; read storage at latched address into instr register; go RESP (exactly one cycle).
REQ-018 RESP: instr_valid=1, instr stable; ack=0 -> stay; ack=1 and req=0 -> IDLE; ack=1 and req=1 -> latch new address, go READ.
REQ-019 ready in RESP equals ack (accept-on-complete); ready=0 whenever ack=0 in RESP.
REQ-020 Latency: acceptance edge N -> instr_valid high from cycle N+2; back-to-back throughput one word per two cycles.
REQ-021 Accepted transaction always completes; req dropping after acceptance has no effect.
REQ-022 ack while instr_valid=0 is ignored.
REQ-023 Write and read of same address in READ-cycle: instr returns pre-write data; subsequent fetch returns new data.
REQ-024 Writes to an address already captured in RESP do not alter instr.
REQ-025 Address wrap: all 2**ADDR_W addresses valid; no range error.

Reset
REQ-026 rst=0 at edge: state IDLE, instr_valid=0, instr=0, latched address=0, ready=1 from next cycle.
REQ-027 Reset mid-transaction (READ or RESP) discards the transaction; no instr_valid pulse follows.
REQ-028 Storage contents unaffected by reset.
REQ-029 wr_en ignored during reset cycle.

Structure
REQ-030 Shared package holds ADDR_W/DATA_W defaults and the FSM state encoding (IDLE=0, READ=1, RESP=2).
REQ-031 Storage array as one sub-module instr_store (sync write, registered read enable); FSM and handshake in top.

Verification
REQ-032 Load: write 0x3A@5, 0xC1@6; req with address=5 at edge N -> instr_valid at N+2, instr=0x3A.
REQ-033 Stall: hold ack=0 for 4 cycles in RESP -> instr=0x3A stable, ready=0, instr_valid=1 throughout.
REQ-034 Back-to-back: ack=1 with req=1, address=6 -> instr_valid drops one cycle, then instr=0xC1.
REQ-035 Collision: in READ of address 5, write 0x77@5 -> instr=0x3A; next fetch of 5 -> 0x77.
REQ-036 Reset in READ: rst=0 one cycle -> instr_valid stays 0, ready=1, instr=0; storage still 0x77@5.
REQ-037 Wrap: write 0xFF@31, 0x11@0; fetch 31 then 0 -> 0xFF then 0x11.
